// File: rtl/add8_shared_rr_sched.sv
// Round-robin scheduler that time-shares one external 8-bit approximate adder between NREQ requesters.
// Optional approximation-error counter is built when ADD8_ERR_TRACK_EN is defined.
module add8_shared_rr_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [8*NREQ-1:0] req_a,
   input  logic [8*NREQ-1:0] req_b,
   output logic [7:0]        add_a,
   output logic [7:0]        add_b,
   input  logic [8:0]        add_o,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [8:0]        rsp_sum,
   output logic [IDW-1:0]    rsp_id,
   output logic              busy,
   output logic [CNTW-1:0]   err_cnt
);

   // Occupancy state: bit 1 = operand stage valid, bit 0 = result stage valid.
   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      ONE_S1 = 2'b01,
      ONE_S0 = 2'b10,
      FULL   = 2'b11
   } occ_e;

   occ_e            state_q;
   occ_e            state_d;
   logic            s0_v;
   logic            s0_n;
   logic            rv_n;
   logic [IDW-1:0]  s0_id;
   logic [IDW-1:0]  ptr_q;
   logic [IDW-1:0]  gnt_id;
   logic [IDW-1:0]  scan_idx;
   logic [NREQ-1:0] grant;
   logic            gnt_any;
   logic            adv1;
   logic            can0;
   logic            stall;
   logic            hs;
   logic [7:0]      sel_a;
   logic [7:0]      sel_b;

   assign s0_v      = state_q[1];
   assign rsp_valid = state_q[0];
   assign busy      = (state_q != EMPTY);

   // Both stages full with the result not taken: nothing can move, no grants.
   assign stall     = (state_q == FULL) & ~rsp_ready;
   assign adv1      = s0_v & (~rsp_valid | rsp_ready);
   assign can0      = ~stall;
   assign req_ready = can0 ? grant : '0;
   assign hs        = can0 & gnt_any;

   always_comb begin
      grant    = '0;
      gnt_id   = '0;
      gnt_any  = 1'b0;
      scan_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!gnt_any && req_valid[scan_idx]) begin
            gnt_any         = 1'b1;
            gnt_id          = scan_idx;
            grant[scan_idx] = 1'b1;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[8*i +: 8];
            sel_b = req_b[8*i +: 8];
         end
      end
   end

   always_comb begin
      s0_n = s0_v;
      rv_n = rsp_valid;
      if (hs) begin
         s0_n = 1'b1;
      end else if (adv1) begin
         s0_n = 1'b0;
      end
      if (adv1) begin
         rv_n = 1'b1;
      end else if (rsp_ready) begin
         rv_n = 1'b0;
      end
      state_d = occ_e'({s0_n, rv_n});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Pointer starts at NREQ-1 so requester 0 wins the first scan after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_a   <= '0;
         add_b   <= '0;
         s0_id   <= '0;
         ptr_q   <= IDW'(NREQ - 1);
         rsp_sum <= '0;
         rsp_id  <= '0;
      end else begin
         if (hs) begin
            add_a <= sel_a;
            add_b <= sel_b;
            s0_id <= gnt_id;
            ptr_q <= gnt_id;
         end
         if (adv1) begin
            rsp_sum <= add_o;
            rsp_id  <= s0_id;
         end
      end
   end

`ifdef ADD8_ERR_TRACK_EN
   logic [8:0] exact_sum;

   assign exact_sum = {1'b0, add_a} + {1'b0, add_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
      end else if (adv1 && (add_o != exact_sum) && (err_cnt != {CNTW{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end
`else
   assign err_cnt = '0;
`endif

endmodule
